multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Multicycle control FSM for the RV64I core.
- Sequences fetch, decode, execute, memory and writeback over the shared datapath (IR, immediate generator, ALU, register file, PC).
- Handles request/acknowledge handshakes to instruction and data memory.
- Drives every datapath select and write-enable, including the immediate-type select consumed by the immediate generator.

## Interface
- WORD_SIZE, 32, instruction width.
- MEM_TIMEOUT, 16, cycles without ack before bus-error trap (min 2).
- i_clk  in  1  core clock, all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  run enable, sampled only in IDLE and at retire.
- i_inst  in  WORD_SIZE  IR contents, stable from the cycle after o_ir_we.
- i_br_taken  in  1  ALU branch-compare result, valid in EXEC.
- i_imem_ack  in  1  instruction memory ack; instruction valid on i_inst bus to IR in same cycle.
- i_dmem_ack  in  1  data memory ack.
- o_imem_req  out  1  instruction fetch request.
- o_dmem_req  out  1  data access request.
- o_dmem_we  out  1  store when 1, load when 0.
- o_ir_we  out  1  IR load strobe.
- o_pc_we  out  1  PC load strobe.
- o_pc_sel  out  2  0 PC+4, 1 PC+imm, 2 ALU result with bit0 cleared.
- o_imm_sel  out  3  0 I, 1 S, 2 B, 3 U, 4 J.
- o_alu_a_sel  out  1  0 rs1, 1 PC.
- o_alu_b_sel  out  1  0 rs2, 1 imm.
- o_rd_we  out  1  register file write strobe.
- o_wb_sel  out  2  0 ALU, 1 load data, 2 PC+4, 3 imm.
- o_retire  out  1  one-cycle pulse per completed instruction.
- o_illegal  out  1  sticky, illegal opcode trap.
- o_bus_err  out  1  sticky, memory timeout trap.

## Operation
- States:
  - IDLE: to FETCH when i_en=1.
  - FETCH: o_imem_req=1. On ack, o_ir_we=1, go to DECODE.
  - DECODE: classify i_inst[6:0]. Go to TRAP if illegal, else EXEC.
  - EXEC: see class rules below.
  - MEM: o_dmem_req=1, o_dmem_we for stores. On ack: store retires, load goes to WB.
  - WB: o_rd_we=1, o_pc_we=1, o_retire=1.
  - TRAP: absorbing state, left only via reset.
- Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Everything else is illegal, including any instruction with i_inst[1:0]≠11.
- EXEC by class:
  - BRANCH: o_pc_we=1, o_pc_sel = i_br_taken ? 1 : 0, o_retire=1.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- Select values by class, held constant from DECODE through retire:
  - OP: imm_sel don't-care (drive 0), a=rs1, b=rs2, wb=ALU.
  - OP-IMM/LOAD/JALR: imm I.
  - STORE: imm S, a=rs1, b=imm.
  - BRANCH: imm B, a=rs1, b=rs2, pc_sel per i_br_taken.
  - LUI: imm U, wb=imm.
  - AUIPC: imm U, a=PC, b=imm, wb=ALU.
  - JAL: imm J, wb=PC+4, pc_sel=1.
  - JALR: a=rs1, b=imm, wb=PC+4, pc_sel=2.
- PC update for stores and non-jump WB is pc_sel=0.
- After retire: go to FETCH if i_en=1, else IDLE. Deasserting i_en mid-instruction never aborts the instruction.
- Timeout counter:
  - Clears on entry to FETCH or MEM and counts each cycle without ack.
  - Reaching MEM_TIMEOUT-1 without ack goes to TRAP and sets o_bus_err; request drops in that cycle.
  - An ack arriving in the same cycle as the timeout wins.
- Acks received while the matching request is low are ignored.
- o_rd_we is asserted even for rd=x0; the register file discards x0 writes.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, every output 0, including sticky flags.
- Outputs are combinational from state plus latched class only, never from i_inst in FETCH. This makes them glitch-free relative to IR load.
- Zero-wait latency (ack in request cycle), FETCH entry to retire pulse:
  - branch 3 cycles.
  - store 4 cycles.
  - ALU, U-type, jump 4 cycles.
  - load 5 cycles.
- Each wait cycle adds one.
- Back-to-back: FETCH of the next instruction starts the cycle after o_retire.
- Request stays high until ack or timeout. No request is dropped and re-raised within one access.

## Structure
- Package rv_ctrl_pkg holds:
  - opcode constants.
  - imm-type, pc_sel and wb_sel encodings.
  - state enum.
  - instruction-class enum.
- Sub-module ctrl_decode: combinational opcode to {class, illegal}, instanced once. The class is registered in DECODE.
- Immediate generator, ALU and register file are external. This block drives only their selects and enables.

## Test plan
- ADDI x1,x0,5 (0x00500093), immediate acks → o_imm_sel=0, o_alu_b_sel=1, o_rd_we and o_retire pulse exactly 4 cycles after FETCH entry.
- BEQ with i_br_taken=1 → o_imm_sel=2, o_pc_sel=1, o_pc_we+o_retire in cycle 3. With i_br_taken=0 → o_pc_sel=0.
- LW with dmem ack delayed 3 cycles → o_dmem_req high for 4 cycles, o_dmem_we=0, o_wb_sel=1, retire at cycle 8.
- Instruction 0x0000007F → o_illegal=1 the cycle after DECODE. No o_rd_we or o_pc_we ever; flag holds until i_rst_n low.
- imem never acks, MEM_TIMEOUT=16 → o_bus_err rises after 16 FETCH cycles, o_imem_req low from then on.
- i_rst_n pulsed low mid-MEM → all outputs 0 immediately, FSM in IDLE. Restarts FETCH only once i_en=1.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV64I multicycle control path: opcodes, datapath
// select codes, FSM states and instruction classes.
package rv_ctrl_pkg;

    // Base opcodes (inst[6:0]); every legal one ends in 2'b11
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic ASEL_RS1 = 1'b0;
    localparam logic ASEL_PC  = 1'b1;
    localparam logic BSEL_RS2 = 1'b0;
    localparam logic BSEL_IMM = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        CL_NONE,
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR,
        CL_BRANCH,
        CL_LOAD,
        CL_STORE,
        CL_OPIMM,
        CL_OP
    } class_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Request/acknowledge handshakes between the control FSM and the
// instruction and data memories.
interface multicycle_ctrl_if;

    logic o_imem_req;
    logic i_imem_ack;
    logic o_dmem_req;
    logic o_dmem_we;
    logic i_dmem_ack;

    modport master (
        output o_imem_req,
        output o_dmem_req,
        output o_dmem_we,
        input  i_imem_ack,
        input  i_dmem_ack
    );

    modport slave (
        input  o_imem_req,
        input  o_dmem_req,
        input  o_dmem_we,
        output i_imem_ack,
        output i_dmem_ack
    );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Opcode classifier: maps inst[6:0] to an instruction class, flagging
// anything outside the supported RV64I base opcodes as illegal.
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output class_e     o_class,
    output logic       o_illegal
);

    always_comb begin
        o_class   = CL_NONE;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_LUI:    o_class = CL_LUI;
            OPC_AUIPC:  o_class = CL_AUIPC;
            OPC_JAL:    o_class = CL_JAL;
            OPC_JALR:   o_class = CL_JALR;
            OPC_BRANCH: o_class = CL_BRANCH;
            OPC_LOAD:   o_class = CL_LOAD;
            OPC_STORE:  o_class = CL_STORE;
            OPC_OPIMM:  o_class = CL_OPIMM;
            OPC_OP:     o_class = CL_OP;
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV64I core: sequences fetch, decode, execute,
// memory and writeback and drives every datapath select and write enable.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int MEM_TIMEOUT = 16   // must be at least 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [WORD_SIZE-1:0] i_inst,
    input  logic                 i_br_taken,
    multicycle_ctrl_if.master    bus,
    output logic                 o_ir_we,
    output logic                 o_pc_we,
    output logic [1:0]           o_pc_sel,
    output logic [2:0]           o_imm_sel,
    output logic                 o_alu_a_sel,
    output logic                 o_alu_b_sel,
    output logic                 o_rd_we,
    output logic [1:0]           o_wb_sel,
    output logic                 o_retire,
    output logic                 o_illegal,
    output logic                 o_bus_err
);

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           r_state;
    class_e           r_class;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;
    logic             r_bus_err;

    state_e     w_next;
    state_e     w_after_retire;
    class_e     w_dec_class;
    class_e     w_cls;
    logic       w_dec_illegal;
    logic       w_timeout;
    logic       w_counting;
    logic       w_sel_act;
    logic       w_imem_req;
    logic       w_dmem_req;
    logic       w_dmem_we;
    logic       w_ir_we;
    logic       w_pc_we;
    logic       w_rd_we;
    logic       w_retire;
    logic       w_set_illegal;
    logic       w_set_bus_err;
    logic [1:0] w_pc_sel;
    logic [2:0] w_imm_sel;
    logic       w_alu_a;
    logic       w_alu_b;
    logic [1:0] w_wb_sel;
    logic       w_inst_unused;

    // Only the opcode field steers control; the rest belongs to the datapath
    assign w_inst_unused = ^i_inst[WORD_SIZE-1:7];

    ctrl_decode u_decode (
        .i_opcode  (i_inst[6:0]),
        .o_class   (w_dec_class),
        .o_illegal (w_dec_illegal)
    );

    assign w_timeout      = (r_cnt == CNT_LAST);
    assign w_counting     = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_after_retire = i_en ? S_FETCH : S_IDLE;

    // IR is stable in DECODE, so the live decode is glitch-free there; later
    // states use the class latched at the end of DECODE.
    assign w_cls     = (r_state == S_DECODE) ? w_dec_class : r_class;
    assign w_sel_act = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                       (r_state == S_MEM)    || (r_state == S_WB);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_imem_req    = 1'b0;
        w_dmem_req    = 1'b0;
        w_dmem_we     = 1'b0;
        w_ir_we       = 1'b0;
        w_pc_we       = 1'b0;
        w_rd_we       = 1'b0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_en) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_imem_req = 1'b1;
                // An ack in the timeout cycle still completes the fetch
                if (bus.i_imem_ack) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_DECODE: begin
                if (w_dec_illegal) begin
                    w_set_illegal = 1'b1;
                    w_next        = S_TRAP;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    CL_BRANCH: begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = w_after_retire;
                    end
                    CL_LOAD, CL_STORE: w_next = S_MEM;
                    default:           w_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_class == CL_STORE);
                if (bus.i_dmem_ack) begin
                    if (r_class == CL_STORE) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = w_after_retire;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_WB: begin
                w_rd_we  = 1'b1;
                w_pc_we  = 1'b1;
                w_retire = 1'b1;
                w_next   = w_after_retire;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_imm_sel = IMM_I;
        w_alu_a   = ASEL_RS1;
        w_alu_b   = BSEL_RS2;
        w_wb_sel  = WB_ALU;
        w_pc_sel  = PC_PLUS4;
        if (w_sel_act) begin
            case (w_cls)
                CL_OPIMM: begin
                    w_alu_b = BSEL_IMM;
                end
                CL_LOAD: begin
                    w_alu_b  = BSEL_IMM;
                    w_wb_sel = WB_LOAD;
                end
                CL_STORE: begin
                    w_imm_sel = IMM_S;
                    w_alu_b   = BSEL_IMM;
                end
                CL_BRANCH: begin
                    w_imm_sel = IMM_B;
                    if ((r_state == S_EXEC) && i_br_taken) begin
                        w_pc_sel = PC_IMM;
                    end
                end
                CL_LUI: begin
                    w_imm_sel = IMM_U;
                    w_wb_sel  = WB_IMM;
                end
                CL_AUIPC: begin
                    w_imm_sel = IMM_U;
                    w_alu_a   = ASEL_PC;
                    w_alu_b   = BSEL_IMM;
                end
                CL_JAL: begin
                    w_imm_sel = IMM_J;
                    w_wb_sel  = WB_PC4;
                    w_pc_sel  = PC_IMM;
                end
                CL_JALR: begin
                    w_alu_b  = BSEL_IMM;
                    w_wb_sel = WB_PC4;
                    w_pc_sel = PC_ALU;
                end
                default: begin
                end
            endcase
        end
    end

    // Wait counter restarts on every state change, so each access gets a fresh budget
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_class   <= CL_NONE;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state == S_DECODE) begin
                r_class <= w_dec_class;
            end
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus.o_imem_req = w_imem_req;
    assign bus.o_dmem_req = w_dmem_req;
    assign bus.o_dmem_we  = w_dmem_we;
    assign o_ir_we        = w_ir_we;
    assign o_pc_we        = w_pc_we;
    assign o_pc_sel       = w_pc_sel;
    assign o_imm_sel      = w_imm_sel;
    assign o_alu_a_sel    = w_alu_a;
    assign o_alu_b_sel    = w_alu_b;
    assign o_rd_we        = w_rd_we;
    assign o_wb_sel       = w_wb_sel;
    assign o_retire       = w_retire;
    assign o_illegal      = r_illegal;
    assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-class selects, latencies, memory waits,
// illegal-opcode and timeout traps, back-to-back issue and async reset.
module tb_multicycle_ctrl;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_BEQ   = 32'h00000463;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_LUI   = 32'h123451B7;
    localparam logic [31:0] I_AUIPC = 32'h00001217;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_JALR  = 32'h000280E7;
    localparam logic [31:0] I_ADD   = 32'h002082B3;

    typedef struct packed {
        logic [1:0] pc_sel;
        logic [2:0] imm;
        logic       a;
        logic       b;
        logic [1:0] wb;
        logic       pc_we;
        logic       rd_we;
    } snap_t;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic [31:0] i_inst;
    logic        i_br_taken;
    logic        o_ir_we;
    logic        o_pc_we;
    logic [1:0]  o_pc_sel;
    logic [2:0]  o_imm_sel;
    logic        o_alu_a_sel;
    logic        o_alu_b_sel;
    logic        o_rd_we;
    logic [1:0]  o_wb_sel;
    logic        o_retire;
    logic        o_illegal;
    logic        o_bus_err;

    int n_vec;
    int n_miscmp;

    int    ret_cyc, ireq_n, dreq_n, rdwe_n, pcwe_n;
    logic  dwe_seen, stable;
    snap_t s;
    int    cnt_a, cnt_b, first_c;
    logic  flag_a, flag_b;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .WORD_SIZE   (32),
        .MEM_TIMEOUT (16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_inst      (i_inst),
        .i_br_taken  (i_br_taken),
        .bus         (bus),
        .o_ir_we     (o_ir_we),
        .o_pc_we     (o_pc_we),
        .o_pc_sel    (o_pc_sel),
        .o_imm_sel   (o_imm_sel),
        .o_alu_a_sel (o_alu_a_sel),
        .o_alu_b_sel (o_alu_b_sel),
        .o_rd_we     (o_rd_we),
        .o_wb_sel    (o_wb_sel),
        .o_retire    (o_retire),
        .o_illegal   (o_illegal),
        .o_bus_err   (o_bus_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] all_outs();
        return {bus.o_imem_req, bus.o_dmem_req, bus.o_dmem_we, o_ir_we, o_pc_we,
                o_pc_sel, o_imm_sel, o_alu_a_sel, o_alu_b_sel, o_rd_we, o_wb_sel,
                o_retire, o_illegal, o_bus_err};
    endfunction

    function automatic snap_t take_snap();
        snap_t t;
        t.pc_sel = o_pc_sel;
        t.imm    = o_imm_sel;
        t.a      = o_alu_a_sel;
        t.b      = o_alu_b_sel;
        t.wb     = o_wb_sel;
        t.pc_we  = o_pc_we;
        t.rd_we  = o_rd_we;
        return t;
    endfunction

    // Entered just after a rising edge in IDLE; returns just after the edge following retire.
    task automatic run_instr(input logic [31:0] inst, input int iwait, input int dwait,
                             input logic taken, input logic en_hold);
        int    ic, dc;
        logic  dec_next, have_ref;
        snap_t s_ref, s_now;
        ic = 0; dc = 0; dec_next = 1'b0; have_ref = 1'b0; s_ref = '0;
        ret_cyc = -1; ireq_n = 0; dreq_n = 0; rdwe_n = 0; pcwe_n = 0;
        dwe_seen = 1'b0; stable = 1'b1; s = '0;
        i_inst = inst; i_br_taken = taken; i_en = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge i_clk); #1;
            i_en = en_hold;
            bus.i_imem_ack = bus.o_imem_req && (ic == iwait);
            bus.i_dmem_ack = bus.o_dmem_req && (dc == dwait);
            #1;
            if (bus.o_imem_req) begin ic++; ireq_n++; end
            if (bus.o_dmem_req) begin
                dc++; dreq_n++;
                if (bus.o_dmem_we) dwe_seen = 1'b1;
            end
            if (o_rd_we) rdwe_n++;
            if (o_pc_we) pcwe_n++;
            s_now = take_snap();
            if (have_ref && ({s_now.imm, s_now.a, s_now.b, s_now.wb} !==
                             {s_ref.imm, s_ref.a, s_ref.b, s_ref.wb})) stable = 1'b0;
            if (dec_next && !have_ref) begin s_ref = s_now; have_ref = 1'b1; end
            if (o_ir_we) dec_next = 1'b1;
            if (o_retire) begin
                ret_cyc = cyc;
                s = s_now;
                break;
            end
        end
        @(posedge i_clk); #1;
        bus.i_imem_ack = 1'b0;
        bus.i_dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        i_en = 1'b0;
        bus.i_imem_ack = 1'b0;
        bus.i_dmem_ack = 1'b0;
        i_rst_n = 1'b0;
        #2;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected $finish within budget");
        $fatal(1, "bench timed out");
    end

    initial begin
        n_vec = 0; n_miscmp = 0;
        i_rst_n = 1'b0; i_en = 1'b0; i_inst = '0; i_br_taken = 1'b0;
        bus.i_imem_ack = 1'b0; bus.i_dmem_ack = 1'b0;
        #12;
        check_vec("reset.held_outs", {14'd0, all_outs()}, 32'd0);
        do_reset();
        check_vec("reset.outs", {14'd0, all_outs()}, 32'd0);

        // Acks with no request outstanding must not move the FSM
        bus.i_imem_ack = 1'b1; bus.i_dmem_ack = 1'b1;
        @(posedge i_clk); @(posedge i_clk); #1;
        check_vec("idle.ack_ignored", {14'd0, all_outs()}, 32'd0);
        bus.i_imem_ack = 1'b0; bus.i_dmem_ack = 1'b0;

        run_instr(I_ADDI, 0, 0, 1'b0, 1'b0);
        check_vec("addi.retire_cyc", ret_cyc, 4);
        check_vec("addi.imm_sel", s.imm, 0);
        check_vec("addi.a_sel", s.a, 0);
        check_vec("addi.b_sel", s.b, 1);
        check_vec("addi.wb_sel", s.wb, 0);
        check_vec("addi.pc_sel", s.pc_sel, 0);
        check_vec("addi.rd_we", {rdwe_n, pcwe_n}, {32'd1, 32'd1});
        check_vec("addi.ireq_cycles", ireq_n, 1);
        check_vec("addi.sel_stable", stable, 1);

        run_instr(I_ADDI, 2, 0, 1'b0, 1'b0);
        check_vec("addi_wait.retire_cyc", ret_cyc, 6);
        check_vec("addi_wait.ireq_cycles", ireq_n, 3);

        run_instr(I_BEQ, 0, 0, 1'b1, 1'b0);
        check_vec("beq_t.retire_cyc", ret_cyc, 3);
        check_vec("beq_t.imm_sel", s.imm, 2);
        check_vec("beq_t.pc_sel", s.pc_sel, 1);
        check_vec("beq_t.ab_sel", {s.a, s.b}, 0);
        check_vec("beq_t.pc_we", s.pc_we, 1);
        check_vec("beq_t.rd_we_cnt", rdwe_n, 0);

        run_instr(I_BEQ, 0, 0, 1'b0, 1'b0);
        check_vec("beq_nt.retire_cyc", ret_cyc, 3);
        check_vec("beq_nt.pc_sel", s.pc_sel, 0);
        check_vec("beq_nt.pc_we", s.pc_we, 1);

        run_instr(I_LW, 0, 3, 1'b0, 1'b0);
        check_vec("lw.retire_cyc", ret_cyc, 8);
        check_vec("lw.dreq_cycles", dreq_n, 4);
        check_vec("lw.dmem_we", dwe_seen, 0);
        check_vec("lw.wb_sel", s.wb, 1);
        check_vec("lw.imm_b_sel", {s.imm, s.b}, {3'd0, 1'b1});
        check_vec("lw.rd_we", s.rd_we, 1);
        check_vec("lw.sel_stable", stable, 1);

        run_instr(I_SW, 0, 0, 1'b0, 1'b0);
        check_vec("sw.retire_cyc", ret_cyc, 4);
        check_vec("sw.dmem_we", dwe_seen, 1);
        check_vec("sw.dreq_cycles", dreq_n, 1);
        check_vec("sw.imm_sel", s.imm, 1);
        check_vec("sw.ab_sel", {s.a, s.b}, 1);
        check_vec("sw.pc", {s.pc_sel, s.pc_we}, {2'd0, 1'b1});
        check_vec("sw.rd_we_cnt", rdwe_n, 0);

        run_instr(I_LUI, 0, 0, 1'b0, 1'b0);
        check_vec("lui.retire_cyc", ret_cyc, 4);
        check_vec("lui.imm_sel", s.imm, 3);
        check_vec("lui.wb_sel", s.wb, 3);

        run_instr(I_AUIPC, 0, 0, 1'b0, 1'b0);
        check_vec("auipc.imm_sel", s.imm, 3);
        check_vec("auipc.ab_sel", {s.a, s.b}, 3);
        check_vec("auipc.wb_sel", s.wb, 0);

        run_instr(I_JAL, 0, 0, 1'b0, 1'b0);
        check_vec("jal.retire_cyc", ret_cyc, 4);
        check_vec("jal.imm_sel", s.imm, 4);
        check_vec("jal.wb_sel", s.wb, 2);
        check_vec("jal.pc_sel", s.pc_sel, 1);

        run_instr(I_JALR, 0, 0, 1'b0, 1'b0);
        check_vec("jalr.imm_sel", s.imm, 0);
        check_vec("jalr.ab_sel", {s.a, s.b}, 1);
        check_vec("jalr.wb_sel", s.wb, 2);
        check_vec("jalr.pc_sel", s.pc_sel, 2);

        run_instr(I_ADD, 0, 0, 1'b0, 1'b0);
        check_vec("add.ab_sel", {s.a, s.b}, 0);
        check_vec("add.wb_imm", {s.wb, s.imm}, 0);
        check_vec("add.rd_we", s.rd_we, 1);

        // Ack in the very cycle the data counter would expire
        run_instr(I_LW, 0, 15, 1'b0, 1'b0);
        check_vec("lw_edge.retire_cyc", ret_cyc, 20);
        check_vec("lw_edge.dreq_cycles", dreq_n, 16);
        check_vec("lw_edge.bus_err", o_bus_err, 0);

        run_instr(I_ADDI, 0, 0, 1'b0, 1'b1);
        check_vec("b2b.retire_cyc", ret_cyc, 4);
        check_vec("b2b.fetch_next", bus.o_imem_req, 1);

        // Carry a load into MEM, then pulse reset while the data request is open
        i_en = 1'b0; i_inst = I_LW; bus.i_imem_ack = 1'b1;
        @(posedge i_clk); #1;
        bus.i_imem_ack = 1'b0;
        @(posedge i_clk); @(posedge i_clk); #1;
        check_vec("rst.in_mem", bus.o_dmem_req, 1);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_vec("rst.async_outs", {14'd0, all_outs()}, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); @(posedge i_clk); #1;
        check_vec("rst.stays_idle", bus.o_imem_req, 0);
        i_en = 1'b1;
        @(posedge i_clk); #1;
        check_vec("rst.restart_fetch", bus.o_imem_req, 1);
        do_reset();

        i_inst = 32'h0000007F; i_en = 1'b1; bus.i_imem_ack = 1'b1;
        cnt_a = 0; cnt_b = 0; flag_a = 1'b0; flag_b = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge i_clk); #2;
            if (o_rd_we || o_pc_we) cnt_a++;
            if (bus.o_imem_req) cnt_b++;
            if (c == 2) flag_a = o_illegal;
            if (c == 3) flag_b = o_illegal;
        end
        check_vec("ill.in_decode", flag_a, 0);
        check_vec("ill.after_decode", flag_b, 1);
        check_vec("ill.sticky", o_illegal, 1);
        check_vec("ill.no_writes", cnt_a, 0);
        check_vec("ill.ireq_cycles", cnt_b, 1);
        do_reset();
        check_vec("ill.cleared", o_illegal, 0);

        i_inst = 32'h00500091; i_en = 1'b1; bus.i_imem_ack = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge i_clk); #2;
        end
        check_vec("ill_lowbits.flag", o_illegal, 1);
        do_reset();

        i_inst = I_ADDI; i_en = 1'b1;
        cnt_a = 0; first_c = 0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge i_clk); #2;
            if (bus.o_imem_req) cnt_a++;
            if (o_bus_err && (first_c == 0)) first_c = c;
        end
        check_vec("tmo.ireq_cycles", cnt_a, 16);
        check_vec("tmo.bus_err_cyc", first_c, 17);
        check_vec("tmo.req_low", bus.o_imem_req, 0);
        check_vec("tmo.no_illegal", o_illegal, 0);
        do_reset();
        check_vec("tmo.cleared", o_bus_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
